// File: rtl/memory_access_arbiter.sv
// Arbitrates the fetch and load/store ports onto the single-ported Memory_System.
// Each access runs IDLE -> ACCESS -> RESP; the winner gets read data and a one-cycle ack.
module memory_access_arbiter #(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0]  TEXT_BASE    = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0]  DATA_BASE    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_data_o,

  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_ack_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,

  output logic [DATA_WIDTH-1:0] mem_range_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic                  addr_err_o
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [DATA_WIDTH-1:0] SegBytes = DATA_WIDTH'(4 * MEMORY_DEPTH);

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_last_d;
  logic                  r_grant_d;
  logic                  r_valid;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_range;
  logic [DATA_WIDTH-1:0] r_if_data;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_err;

  logic                  w_req_any;
  logic                  w_pick_d;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_base;
  logic [DATA_WIDTH-1:0] w_offset;
  logic                  w_addr_ok;
  logic [DATA_WIDTH-1:0] w_rdata_eff;

  // Round-robin: on a tie the port that was not granted last wins.
  assign w_req_any  = if_req_i | d_req_i;
  assign w_pick_d   = d_req_i & (~if_req_i | ~r_last_d);
  assign w_start    = (r_state == StIdle) & w_req_any;
  assign w_sel_addr = w_pick_d ? d_addr_i : if_addr_i;
  assign w_sel_base = w_pick_d ? DATA_BASE : TEXT_BASE;
  assign w_offset   = w_sel_addr - w_sel_base;
  assign w_addr_ok  = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr >= w_sel_base) &&
                      (w_offset < SegBytes);

  // Rejected accesses still complete, but return zero instead of memory contents.
  assign w_rdata_eff = r_valid ? mem_rdata_i : '0;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_req_any) w_state_next = StAccess;
      StAccess: w_state_next = StResp;
      StResp:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_last_d  <= 1'b1;
      r_grant_d <= 1'b0;
      r_valid   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_range   <= TEXT_BASE;
      r_if_data <= '0;
      r_d_rdata <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_grant_d <= w_pick_d;
        r_last_d  <= w_pick_d;
        r_valid   <= w_addr_ok;
        r_we      <= w_pick_d & d_we_i;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_pick_d ? d_wdata_i : '0;
        r_range   <= w_sel_base;
        if (!w_addr_ok) begin
          r_err <= 1'b1;
        end
      end
      if (r_state == StAccess) begin
        if (r_grant_d) begin
          r_d_rdata <= w_rdata_eff;
        end else begin
          r_if_data <= w_rdata_eff;
        end
      end
    end
  end

  assign mem_range_o = r_range;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_we_o    = (r_state == StAccess) & r_we & r_valid;

  assign if_ack_o    = (r_state == StResp) & ~r_grant_d;
  assign d_ack_o     = (r_state == StResp) & r_grant_d;
  assign if_data_o   = r_if_data;
  assign d_rdata_o   = r_d_rdata;
  assign addr_err_o  = r_err;

endmodule
